vga_sync_timing: RTL and testbench
==================================

VGA_SYNC_TIMING -- requirements
Module: vga_sync_timing

Interface
REQ-001 Parameters SHALL be:
- TICK_DIV, 2, clk cycles per pixel (>=1).
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BACK, 33, vertical back porch in lines.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  high = timing advances; low = all state holds.
- pixel_tick  out  1  one-clk strobe per pixel period.
- pixel_x  out  10  horizontal count, 0..H_TOTAL-1.
- pixel_y  out  10  vertical count, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- video_on  out  1  high inside the visible area.
- frame_start  out  1  one-clk pulse on each wrap to (0,0).

Function
REQ-003 Totals SHALL be derived: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
REQ-004 Divider SHALL count 0..TICK_DIV-1 on each enabled clk, then wrap to 0.
REQ-005 pixel_tick SHALL be high exactly while divider == TICK_DIV-1 and enable == 1; with TICK_DIV=1 it is high on every enabled cycle.
REQ-006 pixel_x SHALL increment on each clk edge with pixel_tick == 1, wrapping H_TOTAL-1 -> 0.
REQ-007 pixel_y SHALL increment only on the edge where pixel_x wraps, wrapping V_TOTAL-1 -> 0 on that same edge.
REQ-008 hsync SHALL be 0 iff pixel_x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751); otherwise 1.
REQ-009 vsync SHALL be 0 iff pixel_y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (490..491); otherwise 1.
REQ-010 video_on SHALL be 1 iff pixel_x < H_DISPLAY and pixel_y < V_DISPLAY.
REQ-011 hsync, vsync, video_on and frame_start SHALL be registers. Their values SHALL be decoded from the next-state counters, so they match the pixel_x/pixel_y values presented in the same cycle (zero relative latency).
REQ-012 frame_start SHALL be high for exactly one clk cycle: the cycle in which (pixel_x, pixel_y) first reads (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1). It SHALL never be asserted by reset.
REQ-013 While enable == 0:
- divider, counters and all registered outputs SHALL hold their values.
- pixel_tick SHALL be 0.
- frame_start SHALL be 0.
REQ-014 Outputs SHALL be glitch-free; no output is derived combinationally from an input, except pixel_tick via enable.

Reset
REQ-015 Reset SHALL be sampled only on the rising edge of clk and SHALL dominate enable.
REQ-016 While reset == 0, outputs SHALL be: divider 0, pixel_x 0, pixel_y 0, hsync 1, vsync 1, video_on 0, frame_start 0, pixel_tick 0.
REQ-017 On the first enabled edge after reset release, video_on SHALL become 1, with counters still reading (0,0).
REQ-018 Reset asserted mid-frame SHALL force the REQ-016 values on the next clk edge, with no partial-line completion.

Structure
REQ-019 Shared package vga_timing_pkg SHALL hold:
- the 640x480@60 default constants;
- the counter width constant (10);
- derived H_TOTAL/V_TOTAL.
REQ-020 The divider SHALL be a separate sub-module, pixel_tick_gen (clk, reset, enable -> pixel_tick).
REQ-021 Parameter sets whose H_TOTAL or V_TOTAL exceeds 1024 SHALL be rejected by an elaboration-time check.

Verification
REQ-022 Reset low for 5 clk, then released with enable=1, TICK_DIV=2 -> REQ-016 values during reset; pixel_tick first high in cycle 2 after release; pixel_x=1 in cycle 3.
REQ-023 One full line -> hsync low for exactly 96 ticks starting at pixel_x=656; line period 800 ticks = 1600 clk; pixel_y increments by 1 at the wrap.
REQ-024 One full frame -> vsync low only on lines 490-491; 420000 ticks per frame; frame_start pulses exactly once; video_on high for exactly 307200 ticks.
REQ-025 enable=0 for 50 clk at pixel_x=300, pixel_y=10 -> all outputs frozen at those values, pixel_tick=0; advance resumes at 301 after re-enable.
REQ-026 reset=0 at pixel_x=700, pixel_y=495 -> next edge shows pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=0, and no frame_start pulse.
REQ-027 TICK_DIV=1 -> pixel_tick high every enabled cycle; line period 800 clk.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter width and decode helpers for the VGA sync block.
package vga_timing_pkg;

    // Width of the pixel_x / pixel_y counters; totals must fit in this many bits.
    localparam int unsigned CNT_W     = 10;
    localparam int unsigned CNT_LIMIT = 1 << CNT_W;

    typedef logic [CNT_W-1:0] cnt_t;

    // Default 640x480@60 timing, in pixels and lines.
    localparam int unsigned H_DISPLAY_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_DISPLAY_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // True when v lies in [lo, lo+len-1].
    function automatic logic in_window(cnt_t v, int unsigned lo, int unsigned len);
        return (32'(v) >= lo) && (32'(v) < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_timing_if.sv
// Timing bundle between the sync generator (master) and a pixel consumer (slave).
interface vga_sync_timing_if;
    import vga_timing_pkg::*;

    logic enable;
    logic pixel_tick;
    cnt_t pixel_x;
    cnt_t pixel_y;
    logic hsync;
    logic vsync;
    logic video_on;
    logic frame_start;

    modport master (
        input  enable,
        output pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on, frame_start
    );

    modport slave (
        output enable,
        input  pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on, frame_start
    );

endinterface

// File: rtl/pixel_tick_gen.sv
// Clock divider producing one pixel_tick strobe every TICK_DIV enabled clk cycles.
module pixel_tick_gen #(
    parameter int unsigned TICK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic pixel_tick
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             at_last;

    assign at_last = (div_q == DIV_LAST);

    // Next divider value: count up while enabled, wrap after the last phase.
    always_comb begin
        div_d = div_q;
        if (enable) begin
            div_d = at_last ? '0 : div_q + DIV_W'(1);
        end
    end

    // Divider register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Gated by reset so TICK_DIV=1 cannot strobe while held in reset.
    assign pixel_tick = reset & enable & at_last;

endmodule

// File: rtl/vga_sync_timing.sv
// VGA horizontal/vertical timing generator with registered, zero-latency sync decode.
module vga_sync_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 2,
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input logic               clk,
    input logic               reset,
    vga_sync_timing_if.master vga
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_totals
        $error("vga_sync_timing: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end

    if (TICK_DIV < 1) begin : g_bad_div
        $error("vga_sync_timing: TICK_DIV must be at least 1");
    end

    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

    logic tick;
    logic line_end;
    logic frame_end;

    cnt_t x_q, x_d;
    cnt_t y_q, y_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic video_on_q, video_on_d;
    logic frame_start_q, frame_start_d;

    pixel_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .enable     (vga.enable),
        .pixel_tick (tick)
    );

    assign line_end  = (x_q == H_LAST);
    assign frame_end = line_end && (y_q == V_LAST);

    // Next counter values: x advances per tick, y only on the x wrap.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            x_d = line_end ? '0 : x_q + cnt_t'(1);
            if (line_end) begin
                y_d = (y_q == V_LAST) ? '0 : y_q + cnt_t'(1);
            end
        end
    end

    // Decode from next-state counters so registered syncs line up with the counters.
    always_comb begin
        hsync_d       = !in_window(x_d, H_DISPLAY + H_FRONT, H_SYNC);
        vsync_d       = !in_window(y_d, V_DISPLAY + V_FRONT, V_SYNC);
        video_on_d    = (32'(x_d) < H_DISPLAY) && (32'(y_d) < V_DISPLAY);
        frame_start_d = tick && frame_end;
    end

    // Counters and sync decode; everything holds while enable is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q        <= '0;
            y_q        <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
        end else if (vga.enable) begin
            x_q        <= x_d;
            y_q        <= y_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    // One-shot frame marker; clears on any cycle without a frame wrap, including disabled ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pixel_tick  = tick;
    assign vga.pixel_x     = x_q;
    assign vga.pixel_y     = y_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_timing.sv
// Bench for vga_sync_timing: default timing at TICK_DIV 2 and 1, plus a shrunken raster.
module tb_vga_sync_timing;
    import vga_timing_pkg::*;

    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
    } obs_t;

    typedef struct {
        int td; int hd; int hf; int hs; int hb; int vd; int vf; int vs; int vb;
    } cfg_t;

    typedef struct {
        int div; int x; int y; bit hs; bit vs; bit von; bit fs;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_v [3];
    logic en_v  [3];
    cfg_t cfg   [3];
    mdl_t mdl   [3];
    obs_t exp_q [$];
    int   errors = 0;
    int   checks = 0;

    vga_sync_timing_if vif_a ();
    vga_sync_timing_if vif_b ();
    vga_sync_timing_if vif_c ();

    assign vif_a.enable = en_v[0];
    assign vif_b.enable = en_v[1];
    assign vif_c.enable = en_v[2];

    vga_sync_timing #(.TICK_DIV(2)) dut_a (
        .clk   (clk),
        .reset (rst_v[0]),
        .vga   (vif_a)
    );

    vga_sync_timing #(.TICK_DIV(1)) dut_b (
        .clk   (clk),
        .reset (rst_v[1]),
        .vga   (vif_b)
    );

    // 17 x 11 raster: hsync on x 12..14, vsync on lines 8..9.
    vga_sync_timing #(
        .TICK_DIV (2),
        .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(1)
    ) dut_c (
        .clk   (clk),
        .reset (rst_v[2]),
        .vga   (vif_c)
    );

    function automatic obs_t sample(int id);
        obs_t o;
        case (id)
            0: o = {vif_a.pixel_tick, vif_a.pixel_x, vif_a.pixel_y, vif_a.hsync, vif_a.vsync,
                    vif_a.video_on, vif_a.frame_start};
            1: o = {vif_b.pixel_tick, vif_b.pixel_x, vif_b.pixel_y, vif_b.hsync, vif_b.vsync,
                    vif_b.video_on, vif_b.frame_start};
            default: o = {vif_c.pixel_tick, vif_c.pixel_x, vif_c.pixel_y, vif_c.hsync,
                          vif_c.vsync, vif_c.video_on, vif_c.frame_start};
        endcase
        return o;
    endfunction

    // Reference raster model: state after one clk edge with the given reset/enable.
    function automatic mdl_t model_edge(cfg_t c, mdl_t m, logic rst, logic en);
        mdl_t n;
        int htot;
        int vtot;
        n    = m;
        htot = c.hd + c.hf + c.hs + c.hb;
        vtot = c.vd + c.vf + c.vs + c.vb;
        n.fs = 1'b0;
        if (!rst) begin
            n.div = 0; n.x = 0; n.y = 0; n.hs = 1'b1; n.vs = 1'b1; n.von = 1'b0;
        end else if (en) begin
            if (m.div == c.td - 1) begin
                n.div = 0;
                if (m.x == htot - 1) begin
                    n.x = 0;
                    if (m.y == vtot - 1) begin
                        n.y  = 0;
                        n.fs = 1'b1;
                    end else begin
                        n.y = m.y + 1;
                    end
                end else begin
                    n.x = m.x + 1;
                end
            end else begin
                n.div = m.div + 1;
            end
            n.hs  = !(n.x >= c.hd + c.hf && n.x < c.hd + c.hf + c.hs);
            n.vs  = !(n.y >= c.vd + c.vf && n.y < c.vd + c.vf + c.vs);
            n.von = (n.x < c.hd) && (n.y < c.vd);
        end
        return n;
    endfunction

    function automatic obs_t model_obs(cfg_t c, mdl_t m, logic rst, logic en);
        obs_t o;
        o.tick = rst && en && (m.div == c.td - 1);
        o.x    = 10'(m.x);
        o.y    = 10'(m.y);
        o.hs   = m.hs;
        o.vs   = m.vs;
        o.von  = m.von;
        o.fs   = m.fs;
        return o;
    endfunction

    // One clk: push expectations for every DUT, then pop and compare after the edge.
    task automatic step();
        obs_t got;
        obs_t want;
        for (int i = 0; i < 3; i++) begin
            mdl[i] = model_edge(cfg[i], mdl[i], rst_v[i], en_v[i]);
            exp_q.push_back(model_obs(cfg[i], mdl[i], rst_v[i], en_v[i]));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            want = exp_q.pop_front();
            got  = sample(i);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL scoreboard dut%0d t=%0t: actual tick=%0b x=%0d y=%0d hs=%0b vs=%0b von=%0b fs=%0b required tick=%0b x=%0d y=%0d hs=%0b vs=%0b von=%0b fs=%0b",
                         i, $time, got.tick, got.x, got.y, got.hs, got.vs, got.von, got.fs,
                         want.tick, want.x, want.y, want.hs, want.vs, want.von, want.fs);
            end
        end
    endtask

    task automatic test_reset();
        obs_t o;
        obs_t rst_vals;
        rst_vals = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b0;
            en_v[i]  = 1'b1;
        end
        for (int k = 0; k < 5; k++) begin
            step();
            o = sample(0);
            checks++;
            if (o !== rst_vals) begin
                errors++;
                $display("FAIL reset_values cycle %0d: actual %h required %h", k, o, rst_vals);
            end
        end
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b1;
        #1;
        // Cycle 1 after release: edge not yet seen, divider still 0.
        checks++;
        if (vif_a.pixel_tick !== 1'b0) begin
            errors++;
            $display("FAIL release_cycle1_tick: actual %b required 0", vif_a.pixel_tick);
        end
        checks++;
        if (vif_b.pixel_tick !== 1'b1) begin
            errors++;
            $display("FAIL div1_release_tick: actual %b required 1", vif_b.pixel_tick);
        end
        step();
        o = sample(0);
        checks++;
        if (o.tick !== 1'b1 || o.x !== 10'd0 || o.y !== 10'd0 || o.von !== 1'b1) begin
            errors++;
            $display("FAIL release_cycle2: actual tick=%b x=%0d y=%0d von=%b required tick=1 x=0 y=0 von=1",
                     o.tick, o.x, o.y, o.von);
        end
        step();
        o = sample(0);
        checks++;
        if (o.x !== 10'd1) begin
            errors++;
            $display("FAIL release_cycle3_x: actual %0d required 1", o.x);
        end
    endtask

    task automatic test_line();
        int y0;
        int n;
        int clks;
        int hs_ticks;
        int first_hs;
        int last_hs;
        y0 = int'(vif_a.pixel_y);
        n  = 0;
        while (int'(vif_a.pixel_y) == y0 && n < 4000) begin
            step();
            n++;
        end
        checks++;
        if (int'(vif_a.pixel_y) == y0) begin
            errors++;
            $display("FAIL line_align: actual no line wrap within 4000 clk required wrap");
            return;
        end
        y0       = int'(vif_a.pixel_y);
        clks     = 0;
        hs_ticks = 0;
        first_hs = -1;
        last_hs  = -1;
        while (int'(vif_a.pixel_y) == y0 && clks < 4000) begin
            if (vif_a.pixel_tick && !vif_a.hsync) begin
                hs_ticks++;
                if (first_hs < 0) first_hs = int'(vif_a.pixel_x);
                last_hs = int'(vif_a.pixel_x);
            end
            step();
            clks++;
        end
        checks++;
        if (clks != 1600) begin
            errors++;
            $display("FAIL line_period_clk: actual %0d required 1600", clks);
        end
        checks++;
        if (hs_ticks != 96) begin
            errors++;
            $display("FAIL hsync_width: actual %0d required 96", hs_ticks);
        end
        checks++;
        if (first_hs != 656 || last_hs != 751) begin
            errors++;
            $display("FAIL hsync_window: actual %0d..%0d required 656..751", first_hs, last_hs);
        end
        checks++;
        if (int'(vif_a.pixel_y) != y0 + 1 || vif_a.pixel_x !== 10'd0) begin
            errors++;
            $display("FAIL line_wrap: actual x=%0d y=%0d required x=0 y=%0d",
                     vif_a.pixel_x, vif_a.pixel_y, y0 + 1);
        end
    endtask

    task automatic test_tick_div1();
        int y0;
        int n;
        int clks;
        int ticks;
        y0 = int'(vif_b.pixel_y);
        n  = 0;
        while (int'(vif_b.pixel_y) == y0 && n < 2000) begin
            step();
            n++;
        end
        y0    = int'(vif_b.pixel_y);
        clks  = 0;
        ticks = 0;
        while (int'(vif_b.pixel_y) == y0 && clks < 2000) begin
            if (vif_b.pixel_tick) ticks++;
            step();
            clks++;
        end
        checks++;
        if (clks != 800) begin
            errors++;
            $display("FAIL div1_line_period: actual %0d required 800", clks);
        end
        checks++;
        if (ticks != 800) begin
            errors++;
            $display("FAIL div1_tick_every_cycle: actual %0d required 800", ticks);
        end
    endtask

    task automatic test_enable_freeze();
        int   n;
        obs_t snap;
        obs_t want;
        obs_t o;
        n = 0;
        while (!(int'(vif_a.pixel_x) == 300 && int'(vif_a.pixel_y) == 10) && n < 20000) begin
            step();
            n++;
        end
        checks++;
        if (!(int'(vif_a.pixel_x) == 300 && int'(vif_a.pixel_y) == 10)) begin
            errors++;
            $display("FAIL freeze_reach: actual x=%0d y=%0d required x=300 y=10",
                     vif_a.pixel_x, vif_a.pixel_y);
            return;
        end
        snap     = sample(0);
        want     = snap;
        want.tick = 1'b0;
        want.fs   = 1'b0;
        en_v[0]  = 1'b0;
        #1;
        checks++;
        if (vif_a.pixel_tick !== 1'b0) begin
            errors++;
            $display("FAIL freeze_tick_comb: actual %b required 0", vif_a.pixel_tick);
        end
        for (int k = 0; k < 50; k++) begin
            step();
            o = sample(0);
            checks++;
            if (o !== want) begin
                errors++;
                $display("FAIL freeze_hold cycle %0d: actual %h required %h", k, o, want);
            end
        end
        en_v[0] = 1'b1;
        n = 0;
        while (int'(vif_a.pixel_x) == 300 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (vif_a.pixel_x !== 10'd301 || vif_a.pixel_y !== 10'd10) begin
            errors++;
            $display("FAIL freeze_resume: actual x=%0d y=%0d required x=301 y=10",
                     vif_a.pixel_x, vif_a.pixel_y);
        end
    endtask

    task automatic test_frame();
        int n;
        int clks;
        int ticks;
        int vs_ticks;
        int von_ticks;
        int bad_vs;
        n = 0;
        while (!vif_c.frame_start && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (vif_c.frame_start !== 1'b1 || vif_c.pixel_x !== 10'd0 || vif_c.pixel_y !== 10'd0) begin
            errors++;
            $display("FAIL frame_start_pos: actual fs=%b x=%0d y=%0d required fs=1 x=0 y=0",
                     vif_c.frame_start, vif_c.pixel_x, vif_c.pixel_y);
            return;
        end
        clks = 0; ticks = 0; vs_ticks = 0; von_ticks = 0; bad_vs = 0;
        do begin
            if (vif_c.pixel_tick) begin
                ticks++;
                if (!vif_c.vsync) vs_ticks++;
                if (vif_c.video_on) von_ticks++;
            end
            if (!vif_c.vsync && !(int'(vif_c.pixel_y) inside {8, 9})) bad_vs++;
            step();
            clks++;
        end while (!vif_c.frame_start && clks < 1000);
        checks++;
        if (clks != 374 || ticks != 187) begin
            errors++;
            $display("FAIL frame_period: actual clk=%0d ticks=%0d required clk=374 ticks=187",
                     clks, ticks);
        end
        checks++;
        if (vs_ticks != 34 || bad_vs != 0) begin
            errors++;
            $display("FAIL vsync_lines: actual low_ticks=%0d stray=%0d required low_ticks=34 stray=0",
                     vs_ticks, bad_vs);
        end
        checks++;
        if (von_ticks != 60) begin
            errors++;
            $display("FAIL video_on_ticks: actual %0d required 60", von_ticks);
        end
        step();
        checks++;
        if (vif_c.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL frame_start_width: actual %b required 0", vif_c.frame_start);
        end
    endtask

    task automatic test_mid_reset();
        int   n;
        obs_t o;
        obs_t rst_vals;
        rst_vals = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        n = 0;
        while (!(int'(vif_c.pixel_x) == 13 && int'(vif_c.pixel_y) == 10) && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (!(int'(vif_c.pixel_x) == 13 && int'(vif_c.pixel_y) == 10)) begin
            errors++;
            $display("FAIL midreset_reach: actual x=%0d y=%0d required x=13 y=10",
                     vif_c.pixel_x, vif_c.pixel_y);
            return;
        end
        rst_v[2] = 1'b0;
        step();
        o = sample(2);
        checks++;
        if (o !== rst_vals) begin
            errors++;
            $display("FAIL midreset_values: actual %h required %h", o, rst_vals);
        end
        step();
        rst_v[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (vif_c.frame_start !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_frame_start cycle %0d: actual 1 required 0", k);
            end
        end
    endtask

    initial begin
        cfg[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
        cfg[1] = '{1, 640, 16, 96, 48, 480, 10, 2, 33};
        cfg[2] = '{2, 10, 2, 3, 2, 6, 2, 2, 1};
        for (int i = 0; i < 3; i++) begin
            mdl[i]   = '{0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0};
            rst_v[i] = 1'b0;
            en_v[i]  = 1'b1;
        end
        test_reset();
        test_line();
        test_tick_div1();
        test_enable_freeze();
        test_frame();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
